// File: rtl/hc4_prog_loader_pkg.sv
// Shared definitions for the hc4 program loader: FSM state encodings,
// error codes, the default frame marker and small helpers.
package hc4_prog_loader_pkg;

  typedef enum logic [2:0] {
    ST_IDLE   = 3'd0,
    ST_ADDR_H = 3'd1,
    ST_ADDR_L = 3'd2,
    ST_LEN    = 3'd3,
    ST_DATA   = 3'd4,
    ST_CSUM   = 3'd5
  } ld_state_e;

  typedef enum logic [1:0] {
    ERR_NONE    = 2'd0,
    ERR_CSUM    = 2'd1,
    ERR_TIMEOUT = 2'd2
  } ld_err_e;

  localparam logic [7:0] SYNC_DEFAULT = 8'hA5;
  localparam int         REMAIN_W     = 9;

  // A LEN byte of zero stands for a full 256-byte payload.
  function automatic logic [REMAIN_W-1:0] len_to_count(input logic [7:0] len);
    return (len == 8'h00) ? REMAIN_W'(256) : {1'b0, len};
  endfunction

endpackage

// File: rtl/hc4_timeout_ctr.sv
// Mid-frame idle watchdog: counts cycles without a handshake while a frame
// is open and pulses expire on the cycle the limit is reached.
module hc4_timeout_ctr #(
  parameter int TIMEOUT = 50000,
  parameter int TMO_W   = 16
) (
  input  logic clk,
  input  logic Reset,
  input  logic clear,
  input  logic run,
  output logic expire
);

  localparam logic [TMO_W-1:0] LAST = (TIMEOUT > 0) ? TMO_W'(TIMEOUT - 1) : '0;

  logic [TMO_W-1:0] cnt;

  // A handshake in the same cycle always wins over the expiry.
  always_comb begin
    expire = (TIMEOUT != 0) && run && !clear && (cnt == LAST);
  end

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples pre-edge values regardless of process evaluation order.
  always_ff @(posedge clk or posedge Reset) begin
    if (Reset) begin
      cnt <= '0;
    end else if (clear || !run || expire) begin
      cnt <= '0;
    end else begin
      cnt <= cnt + TMO_W'(1);
    end
  end

endmodule

// File: rtl/hc4_prog_loader.sv
// Byte-stream program loader: parses framed host bytes into hc4 ROM writes,
// holding the core in reset until a frame passes its checksum.
module hc4_prog_loader
  import hc4_prog_loader_pkg::*;
#(
  parameter int         ADDR_W    = 12,
  parameter logic [7:0] SYNC_BYTE = SYNC_DEFAULT,
  parameter int         TIMEOUT   = 50000,
  parameter int         TMO_W     = 16
) (
  input  logic              clk,
  input  logic              Reset,
  input  logic [7:0]        in_data,
  input  logic              in_valid,
  output logic              in_ready,
  output logic              rom_we,
  output logic [ADDR_W-1:0] rom_addr,
  output logic [7:0]        rom_wdata,
  output logic              cpu_nReset,
  output logic              busy,
  output logic              done,
  output logic              err,
  output logic [1:0]        err_code
);

  ld_state_e             state_q, state_d;
  logic [ADDR_W-1:0]     addr_q, addr_d;
  logic [REMAIN_W-1:0]   remain_q, remain_d;
  logic [7:0]            csum_q, csum_d;
  logic                  we_d;
  logic [ADDR_W-1:0]     waddr_d;
  logic [7:0]            wdata_d;
  logic                  nrst_d;
  logic                  done_d;
  logic                  err_d;
  ld_err_e               code_q, code_d;

  logic                  hs;
  logic                  expire;
  logic [7:0]            csum_next;

  assign in_ready  = 1'b1;
  assign hs        = in_valid & in_ready;
  assign busy      = (state_q != ST_IDLE);
  assign err_code  = code_q;
  assign csum_next = csum_q + in_data;

  hc4_timeout_ctr #(
    .TIMEOUT (TIMEOUT),
    .TMO_W   (TMO_W)
  ) u_tmo (
    .clk    (clk),
    .Reset  (Reset),
    .clear  (hs),
    .run    (busy),
    .expire (expire)
  );

  // NOTE: every signal written here gets a default first, so no path through
  // the case statement can leave one unassigned and infer a latch.
  always_comb begin
    state_d  = state_q;
    addr_d   = addr_q;
    remain_d = remain_q;
    csum_d   = csum_q;
    we_d     = 1'b0;
    waddr_d  = rom_addr;
    wdata_d  = rom_wdata;
    nrst_d   = cpu_nReset;
    done_d   = 1'b0;
    err_d    = err;
    code_d   = code_q;

    if (hs) begin
      unique case (state_q)
        ST_IDLE: begin
          if (in_data == SYNC_BYTE) begin
            state_d = ST_ADDR_H;
            nrst_d  = 1'b0;
            err_d   = 1'b0;
            code_d  = ERR_NONE;
            csum_d  = 8'h00;
          end
        end
        ST_ADDR_H: begin
          // Only the low address bits of the high byte survive the truncation.
          addr_d  = ADDR_W'({in_data, 8'h00});
          state_d = ST_ADDR_L;
        end
        ST_ADDR_L: begin
          addr_d  = {addr_q[ADDR_W-1:8], in_data};
          state_d = ST_LEN;
        end
        ST_LEN: begin
          remain_d = len_to_count(in_data);
          state_d  = ST_DATA;
        end
        ST_DATA: begin
          we_d     = 1'b1;
          waddr_d  = addr_q;
          wdata_d  = in_data;
          addr_d   = addr_q + ADDR_W'(1);
          csum_d   = csum_next;
          remain_d = remain_q - REMAIN_W'(1);
          if (remain_q == REMAIN_W'(1)) begin
            state_d = ST_CSUM;
          end
        end
        ST_CSUM: begin
          state_d = ST_IDLE;
          if (csum_next == 8'h00) begin
            done_d = 1'b1;
            nrst_d = 1'b1;
          end else begin
            err_d  = 1'b1;
            code_d = ERR_CSUM;
          end
        end
        default: state_d = ST_IDLE;
      endcase
    end else if (expire) begin
      // The core stays held: a partial program must never run.
      state_d = ST_IDLE;
      err_d   = 1'b1;
      code_d  = ERR_TIMEOUT;
    end
  end

  // NOTE: the write-port registers are reset along with the FSM, so a write
  // registered just before Reset never reaches the ROM.
  always_ff @(posedge clk or posedge Reset) begin
    if (Reset) begin
      state_q    <= ST_IDLE;
      addr_q     <= '0;
      remain_q   <= '0;
      csum_q     <= 8'h00;
      rom_we     <= 1'b0;
      rom_addr   <= '0;
      rom_wdata  <= 8'h00;
      cpu_nReset <= 1'b1;
      done       <= 1'b0;
      err        <= 1'b0;
      code_q     <= ERR_NONE;
    end else begin
      state_q    <= state_d;
      addr_q     <= addr_d;
      remain_q   <= remain_d;
      csum_q     <= csum_d;
      rom_we     <= we_d;
      rom_addr   <= waddr_d;
      rom_wdata  <= wdata_d;
      cpu_nReset <= nrst_d;
      done       <= done_d;
      err        <= err_d;
      code_q     <= code_d;
    end
  end

endmodule

// File: tb/tb_hc4_prog_loader.sv
// Self-checking bench for hc4_prog_loader: table-driven frames plus hand
// sequences for latency, timeout, long frames and mid-frame reset.
module tb_hc4_prog_loader;

  localparam int TMO = 8;

  logic        clk = 1'b0;
  logic        rst;
  logic [7:0]  in_data;
  logic        in_valid;
  logic        in_ready;
  logic        rom_we;
  logic [11:0] rom_addr;
  logic [7:0]  rom_wdata;
  logic        cpu_nReset;
  logic        busy;
  logic        done;
  logic        err;
  logic [1:0]  err_code;

  always #5 clk = ~clk;

  hc4_prog_loader #(
    .ADDR_W    (12),
    .SYNC_BYTE (8'hA5),
    .TIMEOUT   (TMO),
    .TMO_W     (16)
  ) dut (
    .clk        (clk),
    .Reset      (rst),
    .in_data    (in_data),
    .in_valid   (in_valid),
    .in_ready   (in_ready),
    .rom_we     (rom_we),
    .rom_addr   (rom_addr),
    .rom_wdata  (rom_wdata),
    .cpu_nReset (cpu_nReset),
    .busy       (busy),
    .done       (done),
    .err        (err),
    .err_code   (err_code)
  );

  int         total = 0;
  int         bad   = 0;
  logic [7:0] rom_m [4096];
  int         wr_cnt   = 0;
  int         done_cnt = 0;

  // ROM model and pulse counters, sampled mid-cycle.
  always @(negedge clk) begin
    if (rom_we) begin
      rom_m[rom_addr] = rom_wdata;
      wr_cnt++;
    end
    if (done) done_cnt++;
  end

  typedef struct {
    int          n;
    int          off;
    logic [95:0] bytes;
    int          writes;
    logic [11:0] addr0;
    int          dones;
    logic        err;
    logic [1:0]  code;
    logic        nrst;
  } vec_t;

  vec_t vecs [6];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h want %0h", name, act, exp);
    end
  endtask

  task automatic step();
    @(negedge clk);
    #1;
  endtask

  task automatic drive(input logic [7:0] b);
    in_valid = 1'b1;
    in_data  = b;
  endtask

  task automatic send(input logic [7:0] b);
    step();
    drive(b);
  endtask

  task automatic gap(input int n);
    repeat (n) begin
      step();
      in_valid = 1'b0;
    end
  endtask

  task automatic clear_model();
    for (int a = 0; a < 4096; a++) rom_m[a] = 8'h00;
    wr_cnt   = 0;
    done_cnt = 0;
  endtask

  task automatic apply_vec(input int idx, input vec_t v);
    logic [11:0] a;
    logic [7:0]  eb;
    clear_model();
    for (int i = 0; i < v.n; i++) send(v.bytes[95-8*i -: 8]);
    gap(1);
    repeat (3) step();
    check($sformatf("v%0d writes", idx), wr_cnt, v.writes);
    check($sformatf("v%0d dones", idx), done_cnt, v.dones);
    check($sformatf("v%0d err", idx), err, v.err);
    check($sformatf("v%0d err_code", idx), err_code, v.code);
    check($sformatf("v%0d cpu_nReset", idx), cpu_nReset, v.nrst);
    check($sformatf("v%0d busy", idx), busy, 1'b0);
    for (int k = 0; k < v.writes; k++) begin
      a  = v.addr0 + 12'(k);
      eb = v.bytes[95-8*(v.off+4+k) -: 8];
      check($sformatf("v%0d rom[%0h]", idx, a), rom_m[a], eb);
    end
  endtask

  initial begin
    logic [7:0] d;
    logic [7:0] sum;

    vecs[0] = '{8,  0, 96'hA5_00_10_03_11_22_33_9A_00_00_00_00, 3, 12'h010, 1, 1'b0, 2'd0, 1'b1};
    vecs[1] = '{7,  0, 96'hA5_0F_FF_02_AA_BB_9B_00_00_00_00_00, 2, 12'hFFF, 1, 1'b0, 2'd0, 1'b1};
    vecs[2] = '{8,  0, 96'hA5_00_10_03_11_22_33_00_00_00_00_00, 3, 12'h010, 0, 1'b1, 2'd1, 1'b0};
    vecs[3] = '{8,  0, 96'hA5_00_10_03_11_22_33_9A_00_00_00_00, 3, 12'h010, 1, 1'b0, 2'd0, 1'b1};
    vecs[4] = '{11, 3, 96'h00_FF_5A_A5_00_10_03_11_22_33_9A_00, 3, 12'h010, 1, 1'b0, 2'd0, 1'b1};
    vecs[5] = '{7,  0, 96'hA5_F1_00_02_A5_5B_00_00_00_00_00_00, 2, 12'h100, 1, 1'b0, 2'd0, 1'b1};

    rst      = 1'b1;
    in_valid = 1'b0;
    in_data  = 8'h00;
    clear_model();
    repeat (2) step();
    check("rst in_ready", in_ready, 1'b1);
    check("rst rom_we", rom_we, 1'b0);
    check("rst rom_addr", rom_addr, 12'h000);
    check("rst rom_wdata", rom_wdata, 8'h00);
    check("rst cpu_nReset", cpu_nReset, 1'b1);
    check("rst busy", busy, 1'b0);
    check("rst done", done, 1'b0);
    check("rst err", err, 1'b0);
    check("rst err_code", err_code, 2'd0);
    rst = 1'b0;
    step();

    // Frame 1 cycle by cycle: hold timing, write latency, done pulse.
    clear_model();
    step(); drive(8'hA5);
    step(); check("t1 nrst low after sync", cpu_nReset, 1'b0);
            check("t1 busy", busy, 1'b1);
            drive(8'h00);
    step(); drive(8'h10);
    step(); drive(8'h03);
    step(); check("t1 no write before data", rom_we, 1'b0);
            drive(8'h11);
    step(); check("t1 we d0", rom_we, 1'b1);
            check("t1 addr d0", rom_addr, 12'h010);
            check("t1 wdata d0", rom_wdata, 8'h11);
            drive(8'h22);
    step(); drive(8'h33);
    step(); check("t1 addr d2", rom_addr, 12'h012);
            check("t1 wdata d2", rom_wdata, 8'h33);
            check("t1 nrst held before csum", cpu_nReset, 1'b0);
            drive(8'h9A);
    step(); check("t1 done", done, 1'b1);
            check("t1 nrst released", cpu_nReset, 1'b1);
            check("t1 err", err, 1'b0);
            check("t1 busy end", busy, 1'b0);
            in_valid = 1'b0;
    step(); check("t1 done one cycle", done, 1'b0);
            check("t1 writes", wr_cnt, 3);

    for (int i = 0; i < 6; i++) apply_vec(i, vecs[i]);

    // Timeout: 7 idle cycles keep the frame open, the 8th aborts it.
    clear_model();
    send(8'hA5);
    send(8'h00);
    gap(1);
    repeat (7) step();
    check("tmo busy at 7 idle", busy, 1'b1);
    step();
    check("tmo busy", busy, 1'b0);
    check("tmo err", err, 1'b1);
    check("tmo err_code", err_code, 2'd2);
    check("tmo cpu_nReset", cpu_nReset, 1'b0);
    check("tmo no writes", wr_cnt, 0);
    apply_vec(10, vecs[0]);

    // LEN=0: 256 bytes with idle gaps, one of them just under the limit.
    clear_model();
    sum = 8'h00;
    send(8'hA5); send(8'h02); send(8'h00); send(8'h00);
    for (int i = 0; i < 256; i++) begin
      d   = 8'(i * 7 + 3);
      sum = sum + d;
      gap((i == 50) ? TMO - 1 : int'($urandom_range(0, 5)));
      send(d);
    end
    send(8'(-sum));
    gap(1);
    repeat (3) step();
    check("len0 writes", wr_cnt, 256);
    check("len0 done", done_cnt, 1);
    check("len0 err", err, 1'b0);
    check("len0 cpu_nReset", cpu_nReset, 1'b1);
    for (int i = 0; i < 256; i++) begin
      d = 8'(i * 7 + 3);
      check($sformatf("len0 rom[%0h]", 12'h200 + 12'(i)), rom_m[12'h200 + 12'(i)], d);
    end

    // Same frame, Reset pulsed right after the 100th data handshake.
    clear_model();
    send(8'hA5); send(8'h02); send(8'h00); send(8'h00);
    for (int i = 0; i < 100; i++) send(8'(i * 7 + 3));
    @(posedge clk);
    #1;
    rst      = 1'b1;
    in_valid = 1'b0;
    step();
    check("mrst rom_we", rom_we, 1'b0);
    check("mrst rom_addr", rom_addr, 12'h000);
    check("mrst rom_wdata", rom_wdata, 8'h00);
    check("mrst cpu_nReset", cpu_nReset, 1'b1);
    check("mrst busy", busy, 1'b0);
    check("mrst done", done, 1'b0);
    check("mrst err", err, 1'b0);
    check("mrst err_code", err_code, 2'd0);
    check("mrst in_ready", in_ready, 1'b1);
    rst = 1'b0;
    repeat (4) step();
    check("mrst writes stopped", wr_cnt, 99);
    check("mrst no done", done_cnt, 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
